// File: rtl/phy_free_list.sv
// Circular FIFO of free physical register tags feeding rename (Rd_phy).
// Commit returns stale tags; a flush rebuilds the post-reset free set.
module phy_free_list #(
  parameter int PHY_W    = 8,
  parameter int NUM_PHY  = 256,
  parameter int NUM_ARCH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_req,
  output logic [PHY_W-1:0] alloc_phy,
  output logic             alloc_valid,
  input  logic             release_valid,
  input  logic [PHY_W-1:0] release_phy,
  input  logic             exception,
  input  logic             mret_sig,
  output logic [PHY_W:0]   free_count,
  output logic             empty,
  output logic             overflow_err
);

  localparam int NUM_FREE = NUM_PHY - NUM_ARCH;
  localparam logic [PHY_W-1:0] TAIL_INIT  = PHY_W'(NUM_FREE);
  localparam logic [PHY_W:0]   COUNT_INIT = (PHY_W+1)'(NUM_FREE);
  localparam logic [PHY_W:0]   COUNT_FULL = (PHY_W+1)'(NUM_PHY);

  // Handshake: a tag is consumed on every rising edge where alloc_valid is
  // high; alloc_req is a request, not held. Release has no back-pressure.

  logic [PHY_W-1:0] mem_q [NUM_PHY];
  logic [PHY_W-1:0] mem_d [NUM_PHY];
  logic [PHY_W-1:0] head_q, head_d;
  logic [PHY_W-1:0] tail_q, tail_d;
  logic [PHY_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;

  logic flush;
  logic grant;
  logic rel_ok;
  logic rel_accept;
  logic full;

  function automatic logic [PHY_W-1:0] init_entry(input int idx);
    return (idx < NUM_FREE) ? PHY_W'(idx + NUM_ARCH) : '0;
  endfunction

  assign flush = exception | mret_sig;
  assign full  = (count_q == COUNT_FULL);
  assign grant = alloc_req & (count_q != '0) & ~flush;
  assign rel_ok = release_valid & (release_phy != '0) & ~flush;
  // A full FIFO can still take a release when a grant frees a slot on the same edge.
  assign rel_accept = rel_ok & (~full | grant);

  assign alloc_valid  = grant;
  assign alloc_phy    = grant ? mem_q[head_q] : '0;
  assign free_count   = count_q;
  assign empty        = (count_q == '0);
  assign overflow_err = overflow_q;

  always_comb begin
    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      for (int i = 0; i < NUM_PHY; i++) mem_d[i] = init_entry(i);
      head_d  = '0;
      tail_d  = TAIL_INIT;
      count_d = COUNT_INIT;
    end else begin
      if (rel_accept) begin
        mem_d[tail_q] = release_phy;
        tail_d        = tail_q + 1'b1;
      end
      if (grant) head_d = head_q + 1'b1;
      if (rel_ok && !rel_accept) overflow_d = 1'b1;
      case ({rel_accept, grant})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PHY; i++) mem_q[i] <= init_entry(i);
      head_q     <= '0;
      tail_q     <= TAIL_INIT;
      count_q    <= COUNT_INIT;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_phy_free_list.sv
// Bench for phy_free_list: queue-based free-list model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_phy_free_list;

  logic       clk = 1'b0;
  logic       reset;
  logic       alloc_req;
  logic [7:0] alloc_phy;
  logic       alloc_valid;
  logic       release_valid;
  logic [7:0] release_phy;
  logic       exception;
  logic       mret_sig;
  logic [8:0] free_count;
  logic       empty;
  logic       overflow_err;

  phy_free_list dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_req    (alloc_req),
    .alloc_phy    (alloc_phy),
    .alloc_valid  (alloc_valid),
    .release_valid(release_valid),
    .release_phy  (release_phy),
    .exception    (exception),
    .mret_sig     (mret_sig),
    .free_count   (free_count),
    .empty        (empty),
    .overflow_err (overflow_err)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model: ordered list of free tags plus the sticky error flag
  logic [7:0] exp_q[$];
  logic       model_ovf;
  logic       samp_valid;
  logic [7:0] samp_phy;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_rebuild();
    exp_q.delete();
    for (int i = 32; i < 256; i++) exp_q.push_back(8'(i));
  endtask

  // driver + per-cycle compare: inputs applied after posedge, outputs sampled at negedge
  task automatic cycle(input logic req, input logic rv, input logic [7:0] rp,
                       input logic exc, input logic mr);
    logic       flush;
    logic       exp_valid;
    logic [7:0] exp_phy;
    alloc_req     = req;
    release_valid = rv;
    release_phy   = rp;
    exception     = exc;
    mret_sig      = mr;
    @(negedge clk);
    flush     = exc | mr;
    exp_valid = req && (exp_q.size() != 0) && !flush;
    exp_phy   = exp_valid ? exp_q[0] : 8'd0;
    chk("alloc_valid", int'(alloc_valid), int'(exp_valid));
    chk("alloc_phy", int'(alloc_phy), int'(exp_phy));
    chk("free_count", int'(free_count), exp_q.size());
    chk("empty", int'(empty), int'(exp_q.size() == 0));
    chk("overflow_err", int'(overflow_err), int'(model_ovf));
    samp_valid = alloc_valid;
    samp_phy   = alloc_phy;
    if (flush) begin
      model_rebuild();
    end else begin
      logic was_full;
      was_full = (exp_q.size() == 256);
      if (exp_valid) void'(exp_q.pop_front());
      if (rv && rp != 8'd0) begin
        if (was_full && !exp_valid) model_ovf = 1'b1;
        else exp_q.push_back(rp);
      end
    end
    @(posedge clk);
    #1;
    alloc_req     = 1'b0;
    release_valid = 1'b0;
    release_phy   = 8'd0;
    exception     = 1'b0;
    mret_sig      = 1'b0;
  endtask

  initial begin
    reset = 1'b0; alloc_req = 1'b0; release_valid = 1'b0; release_phy = 8'd0;
    exception = 1'b0; mret_sig = 1'b0;
    model_rebuild();
    model_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // reset state and first allocations
    chk("reset_count", int'(free_count), 224);
    chk("reset_empty", int'(empty), 0);
    cycle(1, 0, 0, 0, 0); chk("first_alloc", int'(samp_phy), 32);
    cycle(1, 0, 0, 0, 0); chk("second_alloc", int'(samp_phy), 33);
    cycle(1, 0, 0, 0, 0); chk("third_alloc", int'(samp_phy), 34);
    chk("count_after3", int'(free_count), 221);

    // drain to empty
    for (int i = 0; i < 221; i++) cycle(1, 0, 0, 0, 0);
    chk("last_alloc", int'(samp_phy), 255);
    chk("drained_empty", int'(empty), 1);
    cycle(1, 0, 0, 0, 0);
    chk("empty_no_grant", int'(samp_valid), 0);
    chk("empty_phy_zero", int'(samp_phy), 0);

    // release order
    cycle(0, 1, 8'd40, 0, 0);
    cycle(0, 1, 8'd7, 0, 0);
    chk("count_two", int'(free_count), 2);
    cycle(1, 0, 0, 0, 0); chk("fifo_first", int'(samp_phy), 40);
    cycle(1, 0, 0, 0, 0); chk("fifo_second", int'(samp_phy), 7);

    // pointers sit at 226: forty releases wrap the tail, forty grants wrap the head
    for (int i = 0; i < 40; i++) cycle(0, 1, 8'(100 + i), 0, 0);
    cycle(1, 0, 0, 0, 0); chk("wrap_first", int'(samp_phy), 100);
    for (int i = 0; i < 39; i++) cycle(1, 0, 0, 0, 0);
    chk("wrap_last", int'(samp_phy), 139);

    // simultaneous alloc + release
    for (int i = 0; i < 5; i++) cycle(0, 1, 8'(60 + i), 0, 0);
    cycle(1, 1, 8'd99, 0, 0);
    chk("simul_phy", int'(samp_phy), 60);
    chk("simul_count", int'(free_count), 5);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0); chk("simul_tail_tag", int'(samp_phy), 99);
    cycle(1, 1, 8'd99, 0, 0);
    chk("empty_release_no_grant", int'(samp_valid), 0);
    chk("empty_release_count", int'(free_count), 1);
    cycle(1, 0, 0, 0, 0); chk("empty_release_next", int'(samp_phy), 99);

    // flush via exception, then via mret, after mixed traffic
    for (int i = 0; i < 30; i++) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(1, 255)), 0, 0);
    cycle(1, 1, 8'd77, 1, 0);
    chk("exc_no_grant", int'(samp_valid), 0);
    chk("exc_count", int'(free_count), 224);
    cycle(1, 0, 0, 0, 0); chk("exc_next_alloc", int'(samp_phy), 32);
    for (int i = 0; i < 30; i++) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(1, 255)), 0, 0);
    cycle(1, 1, 8'd77, 0, 1);
    chk("mret_no_grant", int'(samp_valid), 0);
    chk("mret_count", int'(free_count), 224);
    cycle(1, 0, 0, 0, 0); chk("mret_next_alloc", int'(samp_phy), 32);

    // release of tag 0 is ignored
    cycle(0, 1, 8'd0, 0, 0);
    chk("zero_release", int'(free_count), 223);

    // overflow: fill to 256, then one more release
    for (int i = 0; i < 33; i++) cycle(0, 1, 8'(i + 1), 0, 0);
    chk("full_count", int'(free_count), 256);
    chk("no_ovf_yet", int'(overflow_err), 0);
    cycle(1, 1, 8'd5, 0, 0);
    chk("full_simul_no_ovf", int'(overflow_err), 0);
    cycle(0, 1, 8'd9, 0, 0);
    chk("ovf_set", int'(overflow_err), 1);
    chk("ovf_count", int'(free_count), 256);
    cycle(0, 0, 0, 1, 0);
    chk("ovf_held_flush", int'(overflow_err), 1);
    chk("ovf_flush_count", int'(free_count), 224);

    // asynchronous reset mid-cycle
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0);
    alloc_req = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("async_count", int'(free_count), 224);
    chk("async_ovf", int'(overflow_err), 0);
    chk("async_phy", int'(alloc_phy), 32);
    @(posedge clk);
    #1 reset = 1'b1;
    alloc_req = 1'b0;
    model_rebuild();
    model_ovf = 1'b0;

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic       r_req, r_rv, r_exc, r_mr;
      logic [7:0] r_tag;
      r_req = ($urandom_range(0, 99) < 50);
      r_rv  = ($urandom_range(0, 99) < 48);
      r_tag = ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      r_exc = ($urandom_range(0, 99) == 0);
      r_mr  = ($urandom_range(0, 99) == 0);
      cycle(r_req, r_rv, r_tag, r_exc, r_mr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
